// File: rtl/never8_ctrl.sv
// Never8 fetch/decode/execute controller.
// Drives the ALU, owns pc/ir/acc/flags and the output port.
module never8_ctrl #(
  parameter int              PC_W     = 5,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  output logic [2:0]      alu_opcode,
  output logic [4:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_data_out,
  input  logic            alu_c,
  input  logic            alu_zflag,
  output logic [7:0]      acc,
  output logic            flag_z,
  output logic            flag_c,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            halted
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    OUT_WAIT,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_JMP  = 3'b001,
    OP_JZ   = 3'b010,
    OP_LDI  = 3'b011,
    OP_OUT  = 3'b100,
    OP_JC   = 3'b101,
    OP_NOP  = 3'b110,
    OP_HALT = 3'b111
  } op_t;

  state_t          state, state_d;
  logic [PC_W-1:0] pc, pc_d;
  logic [7:0]      ir, ir_d;
  logic [7:0]      acc_d;
  logic            fz_d, fc_d;
  logic [7:0]      od_d;
  logic            ov_d;

  op_t             op;
  logic [4:0]      imm;

  assign op  = op_t'(ir[7:5]);
  assign imm = ir[4:0];

  assign imem_addr = pc;
  assign alu_a     = imm;
  assign alu_b     = acc;
  assign halted    = (state == HALT);

  // Idle opcode outside an ADD execute keeps
  // the ALU's z=1 default away from the flags.
  assign alu_opcode =
    (state == EXECUTE && op == OP_ADD)
      ? 3'b000 : 3'b111;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= 8'h00;
      acc       <= 8'h00;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      ir        <= ir_d;
      acc       <= acc_d;
      flag_z    <= fz_d;
      flag_c    <= fc_d;
      out_data  <= od_d;
      out_valid <= ov_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    ir_d    = ir;
    acc_d   = acc;
    fz_d    = flag_z;
    fc_d    = flag_c;
    od_d    = out_data;
    ov_d    = out_valid;
    unique case (state)
      FETCH: begin
        if (run) state_d = DECODE;
      end
      DECODE: begin
        ir_d    = imem_data;
        pc_d    = pc + PC_W'(1);
        state_d = EXECUTE;
      end
      EXECUTE: begin
        state_d = FETCH;
        unique case (op)
          OP_ADD: begin
            acc_d = alu_data_out;
            fc_d  = alu_c;
            fz_d  = alu_zflag;
          end
          OP_JMP: pc_d = PC_W'(imm);
          OP_JZ: begin
            if (flag_z) pc_d = PC_W'(imm);
          end
          OP_LDI: acc_d = {3'b000, imm};
          OP_OUT: begin
            od_d    = acc;
            ov_d    = 1'b1;
            state_d = OUT_WAIT;
          end
          OP_JC: begin
            if (flag_c) pc_d = PC_W'(imm);
          end
          OP_NOP: ;
          OP_HALT: state_d = HALT;
          default: ;
        endcase
      end
      OUT_WAIT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = FETCH;
        end
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_never8_ctrl.sv
// Self-checking bench for never8_ctrl.
// Models a registered ROM and the 8-bit ALU.
module tb_never8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [4:0] imem_addr;
  logic [7:0] imem_data;
  logic [2:0] alu_opcode;
  logic [4:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_data_out;
  logic       alu_c;
  logic       alu_zflag;
  logic [7:0] acc;
  logic       flag_z;
  logic       flag_c;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       halted;

  logic [7:0] rom [32];
  logic [8:0] sum;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  never8_ctrl #(.PC_W(5), .RESET_PC(5'd0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_data_out (alu_data_out),
    .alu_c        (alu_c),
    .alu_zflag    (alu_zflag),
    .acc          (acc),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .halted       (halted)
  );

  always_ff @(posedge clk)
    imem_data <= rom[imem_addr];

  // ALU: add on opcode 000, idle default
  // otherwise (result 0, z=1).
  always_comb begin
    sum          = 9'd0;
    alu_data_out = 8'h00;
    alu_c        = 1'b0;
    alu_zflag    = 1'b1;
    if (alu_opcode == 3'b000) begin
      sum          = {1'b0, alu_b} + {4'b0, alu_a};
      alu_data_out = sum[7:0];
      alu_c        = sum[8];
      alu_zflag    = (sum[7:0] == 8'h00);
    end
  end

  typedef struct {
    logic [4:0] ldi;
    int         n;
    logic [4:0] add;
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic [4:0] pc;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d",
                  name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++)
      rom[i] = 8'hE0;
  endtask

  task automatic do_reset();
    run       = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 200; i++) begin
      if (halted) break;
      step(1);
    end
    chk({name, "_halt"}, int'(halted), 1);
  endtask

  initial begin
    vecs[0] = '{5'd5,  1, 5'd3,  8'd8,   0, 0, 5'd3};
    vecs[1] = '{5'd31, 7, 5'd31, 8'd248, 0, 0, 5'd9};
    vecs[2] = '{5'd31, 8, 5'd31, 8'd23,  1, 0, 5'd10};
    vecs[3] = '{5'd31, 9, 5'd31, 8'd54,  0, 0, 5'd11};
    vecs[4] = '{5'd0,  1, 5'd0,  8'd0,   0, 1, 5'd3};
    vecs[5] = '{5'd1,  0, 5'd0,  8'd1,   0, 0, 5'd2};
    vecs[6] = '{5'd16, 15, 5'd16, 8'd0,  1, 1, 5'd17};

    clear_rom();
    rst_n     = 1'b0;
    run       = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_acc",   int'(acc), 0);
    chk("rst_pc",    int'(imem_addr), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_halt",  int'(halted), 0);
    chk("rst_fz",    int'(flag_z), 0);
    chk("rst_fc",    int'(flag_c), 0);
    chk("rst_odata", int'(out_data), 0);
    chk("rst_aluop", int'(alu_opcode), 7);

    // Table: LDI ldi; n x ADD add; HALT
    foreach (vecs[v]) begin
      clear_rom();
      rom[0] = {3'b011, vecs[v].ldi};
      for (int k = 0; k < vecs[v].n; k++)
        rom[1+k] = {3'b000, vecs[v].add};
      do_reset();
      run = 1'b1;
      wait_halt($sformatf("v%0d", v));
      chk($sformatf("v%0d_acc", v),
          int'(acc), int'(vecs[v].acc));
      chk($sformatf("v%0d_c", v),
          int'(flag_c), int'(vecs[v].c));
      chk($sformatf("v%0d_z", v),
          int'(flag_z), int'(vecs[v].z));
      chk($sformatf("v%0d_pc", v),
          int'(imem_addr), int'(vecs[v].pc));
    end

    // Basic timing: LDI 5; ADD 3; HALT
    clear_rom();
    rom[0] = 8'h65;
    rom[1] = 8'h03;
    do_reset();
    run = 1'b1;
    step(3);
    chk("b_ldi_acc", int'(acc), 5);
    step(2);
    chk("b_aluop", int'(alu_opcode), 0);
    chk("b_alua",  int'(alu_a), 3);
    chk("b_alub",  int'(alu_b), 5);
    step(1);
    chk("b_acc", int'(acc), 8);
    chk("b_fz",  int'(flag_z), 0);
    chk("b_fc",  int'(flag_c), 0);
    chk("b_idle_op", int'(alu_opcode), 7);
    step(2);
    chk("b_halt8", int'(halted), 0);
    step(1);
    chk("b_halt9", int'(halted), 1);
    chk("b_pc",    int'(imem_addr), 3);
    run = 1'b0;
    step(3);
    chk("b_hold", int'(halted), 1);
    chk("b_hold_pc", int'(imem_addr), 3);

    // JZ taken: addr 3 must never run
    clear_rom();
    rom[0] = 8'h60;
    rom[1] = 8'h00;
    rom[2] = 8'h46;
    rom[3] = 8'h75;
    do_reset();
    run = 1'b1;
    step(9);
    chk("jz_t_pc", int'(imem_addr), 6);
    chk("jz_t_fz", int'(flag_z), 1);
    wait_halt("jz_t");
    chk("jz_t_acc", int'(acc), 0);
    chk("jz_t_hpc", int'(imem_addr), 7);

    // JZ not taken
    clear_rom();
    rom[0] = 8'h61;
    rom[1] = 8'h00;
    rom[2] = 8'h46;
    rom[6] = 8'h75;
    do_reset();
    run = 1'b1;
    step(9);
    chk("jz_n_pc", int'(imem_addr), 3);
    wait_halt("jz_n");
    chk("jz_n_acc", int'(acc), 1);
    chk("jz_n_hpc", int'(imem_addr), 4);

    // JC taken after carry
    clear_rom();
    rom[0] = 8'h7F;
    for (int k = 1; k <= 8; k++)
      rom[k] = 8'h1F;
    rom[9]  = 8'hB4;
    rom[10] = 8'h63;
    do_reset();
    run = 1'b1;
    wait_halt("jc");
    chk("jc_acc", int'(acc), 23);
    chk("jc_pc",  int'(imem_addr), 21);

    // OUT handshake: LDI 17; OUT; HALT
    clear_rom();
    rom[0] = 8'h71;
    rom[1] = 8'h80;
    do_reset();
    run = 1'b1;
    step(5);
    chk("o_pre_valid", int'(out_valid), 0);
    step(1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("o_valid%0d", i),
          int'(out_valid), 1);
      chk($sformatf("o_data%0d", i),
          int'(out_data), 17);
      chk($sformatf("o_nohalt%0d", i),
          int'(halted), 0);
      if (i < 3) step(1);
    end
    out_ready = 1'b1;
    step(1);
    chk("o_drop", int'(out_valid), 0);
    out_ready = 1'b0;
    chk("o_keep", int'(out_data), 17);
    wait_halt("o");
    chk("o_pc", int'(imem_addr), 3);

    // run gating, mid-instruction stall, pc wrap
    clear_rom();
    rom[0]  = 8'h3F;
    rom[31] = 8'hC0;
    do_reset();
    step(5);
    chk("g_pc",   int'(imem_addr), 0);
    chk("g_halt", int'(halted), 0);
    run = 1'b1;
    step(1);
    run = 1'b0;
    step(2);
    chk("g_jmp_pc", int'(imem_addr), 31);
    step(4);
    chk("g_stall_pc", int'(imem_addr), 31);
    run = 1'b1;
    step(2);
    chk("g_wrap_pc", int'(imem_addr), 0);
    chk("g_halt2", int'(halted), 0);

    // Reset during OUT_WAIT
    clear_rom();
    rom[0] = 8'h71;
    rom[1] = 8'h80;
    do_reset();
    run = 1'b1;
    step(7);
    chk("r1_pre", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("r1_valid", int'(out_valid), 0);
    chk("r1_acc",   int'(acc), 0);
    chk("r1_pc",    int'(imem_addr), 0);
    chk("r1_data",  int'(out_data), 0);

    // Reset during EXECUTE of ADD
    clear_rom();
    rom[0] = 8'h65;
    rom[1] = 8'h03;
    do_reset();
    run = 1'b1;
    step(5);
    chk("r2_pre_op", int'(alu_opcode), 0);
    rst_n = 1'b0;
    #1;
    chk("r2_acc", int'(acc), 0);
    chk("r2_pc",  int'(imem_addr), 0);
    step(1);
    chk("r2_nowb", int'(acc), 0);
    chk("r2_nofz", int'(flag_z), 0);
    run = 1'b0;
    rst_n = 1'b1;
    step(3);
    chk("r2_idle_acc", int'(acc), 0);
    chk("r2_idle_pc",  int'(imem_addr), 0);

    $display("%0d/%0d checks passed",
             passed, total);
    $finish;
  end

endmodule

// File: doc/never8_ctrl.md
Name: never8_ctrl

Overview:
Multi-cycle fetch/decode/execute controller for the Never8 8-bit core. It sits directly upstream of the 8-bit ALU and drives the ALU's opcode, 5-bit immediate operand and 8-bit accumulator operand. It consumes the ALU's result, carry and zero outputs into the architectural accumulator and flag registers. It also sequences the program counter against a synchronous instruction ROM and drives a valid/ready output port.

Parameters:
PC_W, 5, program counter / ROM address width; jump targets are the 5-bit immediate, so PC_W must be 5.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  fetch enable; sampled only in FETCH
imem_addr  output  5  ROM address, equals pc
imem_data  input  8  ROM read data, valid one cycle after imem_addr (registered ROM)
alu_opcode  output  3  to ALU opcode
alu_a  output  5  to ALU a (ir[4:0])
alu_b  output  8  to ALU b (acc)
alu_data_out  input  8  ALU result
alu_c  input  1  ALU carry
alu_zflag  input  1  ALU zero
acc  output  8  accumulator register
flag_z  output  1  zero flag register
flag_c  output  1  carry flag register
out_data  output  8  output port data
out_valid  output  1  output port valid
out_ready  input  1  output port ready
halted  output  1  high in HALT state

Behaviour:
- Instruction format: ir[7:5] = op, ir[4:0] = imm.
- Opcodes:
  - 000 ADD: acc <= alu_data_out; flag_c <= alu_c; flag_z <= alu_zflag.
  - 001 JMP: pc <= imm.
  - 010 JZ: pc <= imm if flag_z.
  - 011 LDI: acc <= {3'b000, imm}.
  - 100 OUT: output acc.
  - 101 JC: pc <= imm if flag_c.
  - 110 NOP.
  - 111 HALT.
- Flags change only on ADD. LDI, OUT, jumps and NOP leave them untouched.
- Reset (async, rst_n low) sets:
  - state = FETCH, pc = RESET_PC, ir = 8'h00.
  - acc, flag_z, flag_c, out_data = 0.
  - out_valid = 0, halted = 0.
  - Reset asserted mid-instruction or mid-handshake aborts it immediately; no partial writeback.
- State machine (registered state):
  - FETCH: imem_addr = pc. If run = 1, go to DECODE; otherwise stay in FETCH.
  - DECODE: at the end of the cycle, ir <= imem_data and pc <= pc + 1 (mod 32; 31 wraps to 0). Go to EXECUTE.
  - EXECUTE:
    - Perform the writeback or branch listed above at the end of the cycle.
    - A branch target overrides the incremented pc.
    - OUT: out_data <= acc and out_valid <= 1, then go to OUT_WAIT.
    - HALT: go to HALT.
    - All other ops: go to FETCH.
  - OUT_WAIT:
    - Hold out_valid = 1 with out_data stable.
    - On an edge where out_ready = 1: out_valid <= 0, go to FETCH.
    - out_ready is ignored outside OUT_WAIT.
  - HALT: halted = 1 and the state is held until reset. run has no effect.
- Latency: 3 cycles per instruction (FETCH, DECODE, EXECUTE) with run held high. OUT adds at least 1 OUT_WAIT cycle.
- ALU drive (combinational):
  - alu_opcode = 3'b000 only when state = EXECUTE and op = ADD; otherwise 3'b111 (ALU idle default).
  - alu_a = ir[4:0]; alu_b = acc.
  - ALU outputs are sampled only at the end of an EXECUTE/ADD cycle, so the ALU's default z=1 never reaches flag_z.
- Arithmetic: 8-bit unsigned, acc + zero-extended imm. Carry-out goes to flag_c and acc wraps modulo 256.
- run deasserted mid-instruction does not stall it. The instruction completes, and the controller stalls at the next FETCH.
- Unused ROM contents beyond the program are executed as-is; no bounds checking.

Test Plan:
- Basic add: ROM = LDI 5; ADD 3; HALT with run=1 → after the ADD's EXECUTE: acc=8, flag_z=0, flag_c=0. halted=1 on cycle 9 after reset release; pc=3.
- Carry wrap: LDI 31 followed by 8× ADD 31 → acc after the 7th ADD = 248 with flag_c=0. After the 8th ADD: acc=23 (279 mod 256), flag_c=1, flag_z=0.
- Zero and branches: LDI 0; ADD 0; JZ 6 at address 2; address 6 = HALT → flag_z=1 and the branch is taken: pc=6 and halted=1, with address 3 never fetched. Repeat with LDI 1 → not taken, pc=3 after the JZ.
- OUT handshake: LDI 17; OUT; HALT with out_ready=0 for 4 cycles then 1 → out_valid=1 and out_data=17 stay stable through the stall. The transfer happens on the ready edge, and out_valid drops the next cycle. HALT follows.
- run gating and PC wrap: run=0 → state holds FETCH with imem_addr=0. Then JMP 31 with address 31 = NOP → pc wraps to 0 after address 31 is decoded.
- Reset mid-operation: assert rst_n=0 during OUT_WAIT and during an EXECUTE of ADD → all outputs read reset values asynchronously (acc=0, out_valid=0, pc=0), and no writeback occurs.
